// File: rtl/dma_arb_pkg.sv
// Shared types and constants for the DMA channel arbiter.
// Optional aging support is compiled in with `define DMA_ARB_AGING_EN.
package dma_arb_pkg;

    localparam int PRIO_W_DEF = 2;
    localparam int TMO_W_DEF  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        WAIT = 2'd2,
        REL  = 2'd3
    } arb_state_e;

    function automatic int ch_id_w(input int num_ch);
        if (num_ch > 2) begin
            return $clog2(num_ch);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/dma_rr_pick.sv
// Combinational winner picker: highest priority first, round-robin tie-break after rr_ptr.
// With DMA_ARB_AGING_EN, aged requesters outrank all priorities.
module dma_rr_pick
    import dma_arb_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int PRIO_W = PRIO_W_DEF
) (
    input  logic [NUM_CH-1:0]          req_i,
    input  logic [NUM_CH*PRIO_W-1:0]   prio_i,
    input  logic [ch_id_w(NUM_CH)-1:0] rr_ptr_i,
`ifdef DMA_ARB_AGING_EN
    input  logic [NUM_CH-1:0]          aged_i,
`endif
    output logic [NUM_CH-1:0]          onehot_o,
    output logic [ch_id_w(NUM_CH)-1:0] idx_o,
    output logic                       any_o
);

    localparam int IdW = ch_id_w(NUM_CH);

    logic [PRIO_W-1:0] best_prio_s;
    logic [NUM_CH-1:0] cand_s;
    int                best_dist_s;
    int                dist_s;

    // Candidate set: requesters at the top priority level (or the aged ones)
    always_comb begin
        best_prio_s = PRIO_W'(0);
        for (int i = 0; i < NUM_CH; i++) begin
            if (req_i[i] && (prio_i[i*PRIO_W +: PRIO_W] > best_prio_s)) begin
                best_prio_s = prio_i[i*PRIO_W +: PRIO_W];
            end else begin
                best_prio_s = best_prio_s;
            end
        end
        cand_s = NUM_CH'(0);
        for (int i = 0; i < NUM_CH; i++) begin
            cand_s[i] = req_i[i] && (prio_i[i*PRIO_W +: PRIO_W] == best_prio_s);
        end
`ifdef DMA_ARB_AGING_EN
        if (|(req_i & aged_i)) begin
            cand_s = req_i & aged_i;
        end else begin
            cand_s = cand_s;
        end
`endif
    end

    // Nearest candidate after rr_ptr in circular order wins
    always_comb begin
        best_dist_s = NUM_CH;
        dist_s      = 0;
        idx_o       = IdW'(0);
        for (int i = 0; i < NUM_CH; i++) begin
            dist_s = i - int'(rr_ptr_i) - 1;
            if (dist_s < 0) begin
                dist_s = dist_s + NUM_CH;
            end else begin
                dist_s = dist_s;
            end
            if (cand_s[i] && (dist_s < best_dist_s)) begin
                best_dist_s = dist_s;
                idx_o       = IdW'(i);
            end else begin
                idx_o       = idx_o;
            end
        end
        any_o = |cand_s;
        if (any_o) begin
            onehot_o = NUM_CH'(1) << idx_o;
        end else begin
            onehot_o = NUM_CH'(0);
        end
    end

endmodule

// File: rtl/dma_chan_arbiter.sv
// Arbitrates NUM_CH DMA channels onto one transfer engine with a watchdog.
// Define DMA_ARB_AGING_EN to add per-channel age counters that prevent starvation.
module dma_chan_arbiter
    import dma_arb_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int PRIO_W = PRIO_W_DEF,
    parameter int TMO_W  = TMO_W_DEF
`ifdef DMA_ARB_AGING_EN
    ,
    parameter int AGE_LIMIT = 15
`endif
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_CH-1:0]          ch_req_i,
    input  logic [NUM_CH*PRIO_W-1:0]   ch_prio_i,
    input  logic [TMO_W-1:0]           tmo_cycles_i,
    input  logic                       eng_done_i,
    input  logic                       eng_error_i,
    output logic [NUM_CH-1:0]          ch_grant_o,
    output logic                       eng_start_o,
    output logic [ch_id_w(NUM_CH)-1:0] eng_ch_id_o,
    output logic                       arb_busy_o,
    output logic                       tmo_err_o
);

    localparam int IdW = ch_id_w(NUM_CH);

    arb_state_e        state_q, state_d;
    logic [NUM_CH-1:0] grant_q, grant_d;
    logic [IdW-1:0]    id_q, id_d;
    logic              start_q, start_d;
    logic              busy_q, busy_d;
    logic              tmo_err_q, tmo_err_d;
    logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic [IdW-1:0]    rr_ptr_q, rr_ptr_d;

    logic [NUM_CH-1:0] pick_onehot_s;
    logic [IdW-1:0]    pick_idx_s;
    logic              pick_any_s;
    logic              xfer_end_s;
    logic              tmo_hit_s;

    assign xfer_end_s = eng_done_i | eng_error_i;
    assign tmo_hit_s  = (state_q == WAIT) && (tmo_cycles_i != TMO_W'(0)) &&
                        (tmo_cnt_q == (tmo_cycles_i - TMO_W'(1)));

`ifdef DMA_ARB_AGING_EN
    localparam int AgeW = $clog2(AGE_LIMIT + 1);

    logic [AgeW-1:0]   age_q [NUM_CH];
    logic [NUM_CH-1:0] aged_s;

    // A channel is aged once its counter saturates
    always_comb begin
        aged_s = NUM_CH'(0);
        for (int i = 0; i < NUM_CH; i++) begin
            aged_s[i] = (age_q[i] == AgeW'(AGE_LIMIT));
        end
    end

    // Age counters: requesting losers count up in ARB, the winner clears
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                age_q[i] <= AgeW'(0);
            end
        end else if (state_q == ARB) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (id_q == IdW'(i)) begin
                    age_q[i] <= AgeW'(0);
                end else if (ch_req_i[i] && !aged_s[i]) begin
                    age_q[i] <= age_q[i] + AgeW'(1);
                end
            end
        end
    end
`endif

    dma_rr_pick #(
        .NUM_CH (NUM_CH),
        .PRIO_W (PRIO_W)
    ) u_pick (
        .req_i    (ch_req_i),
        .prio_i   (ch_prio_i),
        .rr_ptr_i (rr_ptr_q),
`ifdef DMA_ARB_AGING_EN
        .aged_i   (aged_s),
`endif
        .onehot_o (pick_onehot_s),
        .idx_o    (pick_idx_s),
        .any_o    (pick_any_s)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a done/error ends the transfer even if the watchdog also hits
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (pick_any_s) begin
                    state_d = ARB;
                end else begin
                    state_d = IDLE;
                end
            end
            ARB: state_d = WAIT;
            WAIT: begin
                if (xfer_end_s || tmo_hit_s) begin
                    state_d = REL;
                end else begin
                    state_d = WAIT;
                end
            end
            REL:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values for the registered outputs, watchdog counter and rr pointer
    always_comb begin
        grant_d   = grant_q;
        id_d      = id_q;
        start_d   = 1'b0;
        tmo_err_d = 1'b0;
        tmo_cnt_d = tmo_cnt_q;
        rr_ptr_d  = rr_ptr_q;
        busy_d    = (state_d != IDLE);
        case (state_q)
            IDLE: begin
                if (pick_any_s) begin
                    grant_d = pick_onehot_s;
                    id_d    = pick_idx_s;
                end else begin
                    grant_d = NUM_CH'(0);
                    id_d    = IdW'(0);
                end
            end
            ARB: start_d = 1'b1;
            WAIT: begin
                tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                tmo_err_d = tmo_hit_s & ~xfer_end_s;
            end
            REL: begin
                grant_d   = NUM_CH'(0);
                id_d      = IdW'(0);
                tmo_cnt_d = TMO_W'(0);
                rr_ptr_d  = id_q;
            end
            default: begin
                grant_d = NUM_CH'(0);
                id_d    = IdW'(0);
            end
        endcase
    end

    // Output, watchdog and pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q   <= NUM_CH'(0);
            id_q      <= IdW'(0);
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            tmo_err_q <= 1'b0;
            tmo_cnt_q <= TMO_W'(0);
            rr_ptr_q  <= IdW'(NUM_CH - 1);
        end else begin
            grant_q   <= grant_d;
            id_q      <= id_d;
            start_q   <= start_d;
            busy_q    <= busy_d;
            tmo_err_q <= tmo_err_d;
            tmo_cnt_q <= tmo_cnt_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    assign ch_grant_o  = grant_q;
    assign eng_start_o = start_q;
    assign eng_ch_id_o = id_q;
    assign arb_busy_o  = busy_q;
    assign tmo_err_o   = tmo_err_q;

endmodule

// File: tb/tb_dma_chan_arbiter.sv
// Self-checking bench for dma_chan_arbiter: directed scenarios plus randomized transfers
// checked against a transaction-level reference model (aging checks under DMA_ARB_AGING_EN).
module tb_dma_chan_arbiter;

    localparam int NUM_CH    = 4;
    localparam int PRIO_W    = 2;
    localparam int TMO_W     = 16;
    localparam int AGE_LIMIT = 3;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [NUM_CH-1:0]        ch_req;
    logic [NUM_CH*PRIO_W-1:0] ch_prio;
    logic [TMO_W-1:0]         tmo_cycles;
    logic                     eng_done;
    logic                     eng_error;
    logic [NUM_CH-1:0]        ch_grant;
    logic                     eng_start;
    logic [1:0]               eng_ch_id;
    logic                     arb_busy;
    logic                     tmo_err;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state: last winner and lost-arbitration counts
    int m_rr;
    int m_age [NUM_CH];

    always #5 clk = ~clk;

    dma_chan_arbiter #(
        .NUM_CH (NUM_CH),
        .PRIO_W (PRIO_W),
        .TMO_W  (TMO_W)
`ifdef DMA_ARB_AGING_EN
        ,
        .AGE_LIMIT (AGE_LIMIT)
`endif
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ch_req_i     (ch_req),
        .ch_prio_i    (ch_prio),
        .tmo_cycles_i (tmo_cycles),
        .eng_done_i   (eng_done),
        .eng_error_i  (eng_error),
        .ch_grant_o   (ch_grant),
        .eng_start_o  (eng_start),
        .eng_ch_id_o  (eng_ch_id),
        .arb_busy_o   (arb_busy),
        .tmo_err_o    (tmo_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic m_reset();
        m_rr = NUM_CH - 1;
        for (int i = 0; i < NUM_CH; i++) m_age[i] = 0;
    endtask

    // Spec rule: highest priority (or any aged channel), ties scanned from last winner + 1
    function automatic int model_pick(input logic [NUM_CH-1:0] req, input logic [NUM_CH*PRIO_W-1:0] prio);
        logic [NUM_CH-1:0] cand;
        int maxp;
        int c;
        cand = '0;
        maxp = -1;
        for (int i = 0; i < NUM_CH; i++)
            if (req[i] && int'(prio[i*PRIO_W +: PRIO_W]) > maxp) maxp = int'(prio[i*PRIO_W +: PRIO_W]);
        for (int i = 0; i < NUM_CH; i++)
            cand[i] = req[i] && (int'(prio[i*PRIO_W +: PRIO_W]) == maxp);
`ifdef DMA_ARB_AGING_EN
        begin
            logic [NUM_CH-1:0] aged;
            aged = '0;
            for (int i = 0; i < NUM_CH; i++) aged[i] = req[i] && (m_age[i] == AGE_LIMIT);
            if (aged != '0) cand = aged;
        end
`endif
        for (int k = 1; k <= NUM_CH; k++) begin
            c = (m_rr + k) % NUM_CH;
            if (cand[c]) return c;
        end
        return 0;
    endfunction

    task automatic m_commit(input logic [NUM_CH-1:0] req, input int w);
        for (int i = 0; i < NUM_CH; i++) begin
            if (i == w) m_age[i] = 0;
            else if (req[i] && m_age[i] < AGE_LIMIT) m_age[i] = m_age[i] + 1;
        end
        m_rr = w;
    endtask

    // One full transfer starting in an IDLE cycle; dly = WAIT cycles before the done pulse
    task automatic run_xfer(input logic [NUM_CH-1:0] req, input logic [NUM_CH*PRIO_W-1:0] prio,
                            input int tmo, input int dly, input int exp_w,
                            input bit use_err, input bit drop, input bit done_in_arb);
        int  end_off;
        bit  tmo_fires;
        ch_req     = req;
        ch_prio    = prio;
        tmo_cycles = 16'(tmo);
        step();
        check_eq("grant_arb", 32'(ch_grant), 32'(1) << exp_w);
        check_eq("id_arb", 32'(eng_ch_id), 32'(exp_w));
        check_eq("start_arb", 32'(eng_start), 32'd0);
        check_eq("busy_arb", 32'(arb_busy), 32'd1);
        if (done_in_arb) eng_done = 1'b1;
        step();
        eng_done = 1'b0;
        if (drop) ch_req = '0;
        check_eq("start_pulse", 32'(eng_start), 32'd1);
        end_off   = dly;
        tmo_fires = 1'b0;
        if (tmo > 0 && (tmo - 1) < dly) begin
            end_off   = tmo - 1;
            tmo_fires = 1'b1;
        end
        for (int c = 0; c <= end_off; c++) begin
            if (c > 0) begin
                step();
                check_eq("start_once", 32'(eng_start), 32'd0);
            end
            if (c == end_off && !tmo_fires) begin
                if (use_err) eng_error = 1'b1;
                else eng_done = 1'b1;
            end
            check_eq("grant_wait", 32'(ch_grant), 32'(1) << exp_w);
            check_eq("tmo_early", 32'(tmo_err), 32'd0);
        end
        step();
        eng_done  = 1'b0;
        eng_error = 1'b0;
        check_eq("tmo_err_rel", 32'(tmo_err), 32'(tmo_fires));
        check_eq("grant_rel", 32'(ch_grant), 32'(1) << exp_w);
        check_eq("busy_rel", 32'(arb_busy), 32'd1);
        step();
        check_eq("grant_idle", 32'(ch_grant), 32'd0);
        check_eq("busy_idle", 32'(arb_busy), 32'd0);
        check_eq("tmo_idle", 32'(tmo_err), 32'd0);
        m_commit(req, exp_w);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        ch_req    = '0;
        eng_done  = 1'b0;
        eng_error = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        m_reset();
    endtask

    initial begin
        logic [NUM_CH-1:0]        r_req;
        logic [NUM_CH*PRIO_W-1:0] r_prio;
        int                       r_tmo;
        rst_n      = 1'b0;
        ch_req     = '0;
        ch_prio    = '0;
        tmo_cycles = '0;
        eng_done   = 1'b0;
        eng_error  = 1'b0;
        m_reset();
        #1;
        check_eq("rst_grant", 32'(ch_grant), 32'd0);
        check_eq("rst_start", 32'(eng_start), 32'd0);
        check_eq("rst_id", 32'(eng_ch_id), 32'd0);
        check_eq("rst_busy", 32'(arb_busy), 32'd0);
        check_eq("rst_tmo", 32'(tmo_err), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        check_eq("idle_no_req", 32'(arb_busy), 32'd0);

        // single request, then strict priority order with winners withdrawing
        run_xfer(4'b0100, 8'h00, 0, 3, 2, 1'b0, 1'b0, 1'b0);
        run_xfer(4'b1111, 8'hD8, 0, 1, 3, 1'b0, 1'b0, 1'b0);
        run_xfer(4'b0111, 8'hD8, 0, 2, 1, 1'b0, 1'b0, 1'b0);
        run_xfer(4'b0101, 8'hD8, 0, 0, 2, 1'b0, 1'b0, 1'b0);
        run_xfer(4'b0001, 8'hD8, 0, 1, 0, 1'b0, 1'b0, 1'b0);

        // round-robin over equal priorities from reset
        do_reset();
        for (int k = 0; k < 8; k++) run_xfer(4'b1111, 8'hAA, 0, k % 3, k % 4, 1'b0, 1'b0, 1'b0);

        // watchdog expiry, done/watchdog collision with request dropped, error ending, stray done in ARB
        run_xfer(4'b0001, 8'h00, 10, 50, 0, 1'b0, 1'b0, 1'b0);
        run_xfer(4'b0010, 8'h00, 10, 9, 1, 1'b0, 1'b1, 1'b0);
        run_xfer(4'b1000, 8'h00, 0, 4, 3, 1'b1, 1'b0, 1'b1);

        // asynchronous reset in the first WAIT cycle
        ch_req  = 4'b0010;
        ch_prio = 8'h00;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("amid_grant", 32'(ch_grant), 32'd0);
        check_eq("amid_start", 32'(eng_start), 32'd0);
        check_eq("amid_busy", 32'(arb_busy), 32'd0);
        ch_req = '0;
        step();
        rst_n = 1'b1;
        m_reset();
        step();
        step();
        check_eq("post_rst_grant", 32'(ch_grant), 32'd0);
        check_eq("post_rst_start", 32'(eng_start), 32'd0);
        run_xfer(4'b1111, 8'h55, 0, 1, 0, 1'b0, 1'b0, 1'b0);

`ifdef DMA_ARB_AGING_EN
        // ch0 (prio 0) against ch1 (prio 3): ch0 wins its 4th arbitration
        do_reset();
        for (int k = 0; k < 4; k++) run_xfer(4'b0011, 8'h0C, 0, 1, (k == 3) ? 0 : 1, 1'b0, 1'b0, 1'b0);
`endif

        // randomized transfers against the reference model
        for (int n = 0; n < 40; n++) begin
            r_req  = 4'($urandom_range(1, 15));
            r_prio = 8'($urandom);
            r_tmo  = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 8));
            run_xfer(r_req, r_prio, r_tmo, int'($urandom_range(0, 10)), model_pick(r_req, r_prio),
                     ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
